// File: rtl/ram_fifo_status_if.sv
// FIFO bus: write/read requests, registered read data and occupancy status.
// Error signals exist only when RAM_FIFO_ERR_EN is defined.
interface ram_fifo_status_if #(
    parameter int DAT_WID        = 24,
    parameter int FIFO_DEPTH_WID = 11
);
    logic                        write_enable;
    logic signed [DAT_WID-1:0]   write_dat;
    logic                        read_enable;
    logic signed [DAT_WID-1:0]   read_dat;
    logic                        read_valid;
    logic                        empty;
    logic                        full;
    logic                        almost_full;
    logic [FIFO_DEPTH_WID:0]     count;
`ifdef RAM_FIFO_ERR_EN
    logic                        overflow;
    logic                        underflow;
    logic                        clr_err;

    modport master (
        output write_enable, write_dat, read_enable, clr_err,
        input  read_dat, read_valid, empty, full, almost_full, count, overflow, underflow
    );
    modport slave (
        input  write_enable, write_dat, read_enable, clr_err,
        output read_dat, read_valid, empty, full, almost_full, count, overflow, underflow
    );
`else
    modport master (
        output write_enable, write_dat, read_enable,
        input  read_dat, read_valid, empty, full, almost_full, count
    );
    modport slave (
        input  write_enable, write_dat, read_enable,
        output read_dat, read_valid, empty, full, almost_full, count
    );
`endif
endinterface

// File: rtl/ram_fifo_status.sv
// RAM FIFO for any depth >= 2 with registered read data (1-cycle latency) and count-derived flags.
// Writes dropped when full unless a read frees a slot; optional sticky errors via RAM_FIFO_ERR_EN.
module ram_fifo_status #(
    parameter int DAT_WID         = 24,
    parameter int FIFO_DEPTH      = 1500,
    parameter int FIFO_DEPTH_WID  = 11,
    parameter int ALMOST_FULL_LVL = 1400
) (
    input  logic               clk,
    input  logic               rst,
    ram_fifo_status_if.slave   bus
);
    localparam int CNT_WID = FIFO_DEPTH_WID + 1;
    localparam logic [CNT_WID-1:0]        DEPTH_C = CNT_WID'(FIFO_DEPTH);
    localparam logic [CNT_WID-1:0]        AF_C    = CNT_WID'(ALMOST_FULL_LVL);
    localparam logic [FIFO_DEPTH_WID-1:0] LAST_C  = FIFO_DEPTH_WID'(FIFO_DEPTH - 1);

    logic signed [DAT_WID-1:0]  mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH_WID-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_DEPTH_WID-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WID-1:0]         count_q, count_d;
    logic signed [DAT_WID-1:0]  read_dat_q, read_dat_d;
    logic                       read_valid_q, read_valid_d;
    logic                       rd_acc, wr_acc;

    function automatic logic [FIFO_DEPTH_WID-1:0] ptr_nxt(input logic [FIFO_DEPTH_WID-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_acc       = bus.read_enable && (count_q != '0);
        // A same-cycle read frees the slot, so a full FIFO still takes the write.
        wr_acc       = bus.write_enable && ((count_q != DEPTH_C) || rd_acc);
        count_d      = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - 1'b1;
        end
        wr_ptr_d     = wr_acc ? ptr_nxt(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d     = rd_acc ? ptr_nxt(rd_ptr_q) : rd_ptr_q;
        read_dat_d   = rd_acc ? mem_q[rd_ptr_q] : read_dat_q;
        read_valid_d = rd_acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            read_dat_q   <= '0;
            read_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            read_dat_q   <= read_dat_d;
            read_valid_q <= read_valid_d;
        end
    end

    // Storage is not reset; when full, the read above samples the old word before this overwrite.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem_q[wr_ptr_q] <= bus.write_dat;
        end
    end

    assign bus.read_dat    = read_dat_q;
    assign bus.read_valid  = read_valid_q;
    assign bus.count       = count_q;
    assign bus.empty       = (count_q == '0);
    assign bus.full        = (count_q == DEPTH_C);
    assign bus.almost_full = (count_q >= AF_C);

`ifdef RAM_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q | (bus.write_enable && !wr_acc);
        // A read on empty alongside a write is treated as served by that write, not as an underflow.
        underflow_d = underflow_q | (bus.read_enable && !rd_acc && !bus.write_enable);
        if (bus.clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_ram_fifo_status.sv
// Directed bench for ram_fifo_status (depth 5): expected read words go into a queue at issue time
// and a negedge monitor pops and compares each read_valid beat; flags/count are checked inline.
module tb_ram_fifo_status;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   exp_q[$];

    ram_fifo_status_if #(.DAT_WID(24), .FIFO_DEPTH_WID(3)) bus ();

    ram_fifo_status #(
        .DAT_WID(24), .FIFO_DEPTH(5), .FIFO_DEPTH_WID(3), .ALMOST_FULL_LVL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every read_valid beat must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (bus.read_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got read_dat=%0d expected no read_valid", $signed(bus.read_dat));
            end else begin
                int e;
                e = exp_q.pop_front();
                if ($signed(bus.read_dat) !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %0d expected %0d", $signed(bus.read_dat), e);
                end
            end
        end
    end

    // One clock: drive, take the edge, settle. ev/ed push the hand-computed read result.
    task automatic cyc(input logic we, input int wd, input logic re, input logic ev, input int ed);
        bus.write_enable = we;
        bus.write_dat    = 24'(wd);
        bus.read_enable  = re;
        if (ev) exp_q.push_back(ed);
        @(posedge clk);
        #1;
        bus.write_enable = 1'b0;
        bus.read_enable  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp3[7];
        exp3 = '{10, 11, 12, 13, 14, 99, 99};
        rst = 1'b1;
        bus.write_enable = 1'b0;
        bus.write_dat    = '0;
        bus.read_enable  = 1'b0;
`ifdef RAM_FIFO_ERR_EN
        bus.clr_err      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_af", int'(bus.almost_full), 0);
        chk("rst_rvalid", int'(bus.read_valid), 0);
        chk("rst_rdat", int'(bus.read_dat), 0);
`ifdef RAM_FIFO_ERR_EN
        chk("rst_ovf", int'(bus.overflow), 0);
        chk("rst_udf", int'(bus.underflow), 0);
`endif
        rst = 1'b0;

        // Basic order with a negative word
        cyc(1, -1, 0, 0, 0);
        cyc(1, 2, 0, 0, 0);
        cyc(1, 3, 0, 0, 0);
        chk("t1_count3", int'(bus.count), 3);
        cyc(0, 0, 1, 1, -1);
        cyc(0, 0, 1, 1, 2);
        cyc(0, 0, 1, 1, 3);
        cyc(0, 0, 0, 0, 0);
        chk("t1_rvalid_idle", int'(bus.read_valid), 0);
        chk("t1_empty", int'(bus.empty), 1);
        chk("t1_count0", int'(bus.count), 0);

        // Fill to full, last word dropped
        for (int i = 10; i <= 13; i++) cyc(1, i, 0, 0, 0);
        chk("t2_count4", int'(bus.count), 4);
        chk("t2_af4", int'(bus.almost_full), 1);
        chk("t2_full4", int'(bus.full), 0);
        cyc(1, 14, 0, 0, 0);
        chk("t2_full5", int'(bus.full), 1);
        chk("t2_count5", int'(bus.count), 5);
        cyc(1, 15, 0, 0, 0);
        chk("t2_count_drop", int'(bus.count), 5);
`ifdef RAM_FIFO_ERR_EN
        chk("t2_ovf", int'(bus.overflow), 1);
        bus.clr_err = 1'b1;
        cyc(0, 0, 0, 0, 0);
        bus.clr_err = 1'b0;
        chk("t2_ovf_clr", int'(bus.overflow), 0);
`endif

        // Full with simultaneous read+write across pointer wrap
        for (int i = 0; i < 7; i++) begin
            cyc(1, 99, 1, 1, exp3[i]);
            chk($sformatf("t3_count_%0d", i), int'(bus.count), 5);
            chk($sformatf("t3_full_%0d", i), int'(bus.full), 1);
        end
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 99);
        cyc(0, 0, 0, 0, 0);
        chk("t3_empty", int'(bus.empty), 1);

        // Empty with simultaneous read+write: write only
        cyc(1, 7, 1, 0, 0);
        chk("t4_count1", int'(bus.count), 1);
        chk("t4_rvalid0", int'(bus.read_valid), 0);
`ifdef RAM_FIFO_ERR_EN
        chk("t4_udf0", int'(bus.underflow), 0);
`endif
        cyc(0, 0, 1, 1, 7);
        cyc(0, 0, 1, 0, 0);
        chk("t4_rvalid_empty_rd", int'(bus.read_valid), 0);
        chk("t4_count_empty_rd", int'(bus.count), 0);
`ifdef RAM_FIFO_ERR_EN
        chk("t4_udf1", int'(bus.underflow), 1);
        bus.clr_err = 1'b1;
        cyc(0, 0, 0, 0, 0);
        bus.clr_err = 1'b0;
        chk("t4_udf_clr", int'(bus.underflow), 0);
`endif

        // Reset mid-operation after an accepted read
        for (int i = 1; i <= 4; i++) cyc(1, i, 0, 0, 0);
        cyc(0, 0, 1, 1, 1);
        chk("t5_count3", int'(bus.count), 3);
        chk("t5_rvalid1", int'(bus.read_valid), 1);
        rst = 1'b1;
        cyc(1, 5, 1, 0, 0);
        rst = 1'b0;
        chk("t5_count0", int'(bus.count), 0);
        chk("t5_empty", int'(bus.empty), 1);
        chk("t5_rvalid0", int'(bus.read_valid), 0);
        chk("t5_rdat0", int'(bus.read_dat), 0);
        cyc(0, 0, 1, 0, 0);
        chk("t5_post_rst_rd", int'(bus.read_valid), 0);
        cyc(0, 0, 0, 0, 0);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
